// File: rtl/instruction_fetch_if.sv
// Purpose: bundles the IF-stage control, debug-loader and IF/ID output signals.
// Ports (slave = fetch stage view):
//   inputs : i_enable, i_stall, i_flush, i_target, i_load_en, i_load_addr, i_load_data
//   outputs: o_instruction, o_pc_plus4, o_pc, o_valid, o_halt
interface instruction_fetch_if #(
    parameter int unsigned NB_PC           = 32,
    parameter int unsigned NB_INSTRUCTIONS = 32,
    parameter int unsigned NB_MEM_ADDR     = 8
);
    logic                       i_enable;
    logic                       i_stall;
    logic                       i_flush;
    logic [NB_PC-1:0]           i_target;
    logic                       i_load_en;
    logic [NB_MEM_ADDR-1:0]     i_load_addr;
    logic [NB_INSTRUCTIONS-1:0] i_load_data;
    logic [NB_INSTRUCTIONS-1:0] o_instruction;
    logic [NB_PC-1:0]           o_pc_plus4;
    logic [NB_PC-1:0]           o_pc;
    logic                       o_valid;
    logic                       o_halt;

    // Upstream driver: debug unit, hazard unit and decoder.
    modport master (
        output i_enable, i_stall, i_flush, i_target,
        output i_load_en, i_load_addr, i_load_data,
        input  o_instruction, o_pc_plus4, o_pc, o_valid, o_halt
    );

    // Fetch stage.
    modport slave (
        input  i_enable, i_stall, i_flush, i_target,
        input  i_load_en, i_load_addr, i_load_data,
        output o_instruction, o_pc_plus4, o_pc, o_valid, o_halt
    );
endinterface

// File: rtl/instruction_fetch.sv
// Purpose: IF stage of the 5-stage MIPS pipeline. Holds the PC, a word-addressed
// instruction memory written by the debug loader, and the IF/ID register.
// Handles decoder stall and flush/redirect, and freezes fetch on HALT.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : instruction_fetch_if.slave (control/load inputs, IF/ID outputs)
module instruction_fetch #(
    parameter int unsigned                NB_PC           = 32,
    parameter int unsigned                NB_INSTRUCTIONS = 32,
    parameter int unsigned                NB_MEM_ADDR     = 8,
    parameter logic [NB_INSTRUCTIONS-1:0] HALT_INSTR      = 32'hFC000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    instruction_fetch_if.slave bus
);
    localparam int unsigned MEM_DEPTH = 2 ** NB_MEM_ADDR;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    logic [NB_INSTRUCTIONS-1:0] mem [MEM_DEPTH];

    state_t                     state_q, state_d;
    logic [NB_PC-1:0]           pc_q, pc_d;
    logic [NB_INSTRUCTIONS-1:0] instr_q, instr_d;
    logic [NB_PC-1:0]           pc4_q, pc4_d;
    logic                       valid_q, valid_d;

    logic [NB_INSTRUCTIONS-1:0] fetch_word;
    logic [NB_PC-1:0]           pc_plus4;

    // Loader write port; memory is never cleared, reset only blocks a write on that edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (i_reset && bus.i_load_en) begin
            mem[bus.i_load_addr] <= bus.i_load_data;
        end
    end

    // Word fetch; byte-offset bits and PC bits above the memory range are ignored.
    assign fetch_word = mem[pc_q[NB_MEM_ADDR+1:2]];
    assign pc_plus4   = pc_q + NB_PC'(4);

    // State register: run/halt plus PC and IF/ID.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    // Next-state: load > disable > halted > flush > stall > normal fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;

        if (!bus.i_load_en && bus.i_enable) begin
            if (state_q == ST_HALT) begin
                // HALT already delivered once; feed bubbles, PC frozen.
                instr_d = '0;
                pc4_d   = pc_plus4;
                valid_d = 1'b0;
            end else if (bus.i_flush) begin
                // Flush beats stall: the stalled fetch is on the wrong path.
                pc_d    = bus.i_target;
                instr_d = '0;
                pc4_d   = '0;
                valid_d = 1'b0;
            end else if (!bus.i_stall) begin
                instr_d = fetch_word;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
                if (fetch_word == HALT_INSTR) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d = pc_plus4;
                end
            end
        end
    end

    assign bus.o_instruction = instr_q;
    assign bus.o_pc_plus4    = pc4_q;
    assign bus.o_pc          = pc_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_halt        = (state_q == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Purpose: scoreboard bench for instruction_fetch. The driver pushes the
// hand-computed IF/ID and PC expected after every clock edge; a monitor pops
// and compares on the following falling edge.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        int          id;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] pc;
        logic        valid;
        logic        halt;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tick_id  = 0;

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at tick %0d: got 0x%08h expected 0x%08h", nm, id, act, exp);
        end
    endtask

    // Monitor: compares the state produced by the preceding rising edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("instruction", e.id, bus.o_instruction, e.instr);
            check("pc_plus4",    e.id, bus.o_pc_plus4,    e.pc4);
            check("pc",          e.id, bus.o_pc,          e.pc);
            check("valid",       e.id, 32'(bus.o_valid),  32'(e.valid));
            check("halt",        e.id, 32'(bus.o_halt),   32'(e.halt));
        end
    end

    // One clock edge with the expected post-edge state; returns at the falling edge.
    task automatic tick(input logic [31:0] ins, input logic [31:0] pc4,
                        input logic [31:0] pc, input logic v, input logic h);
        exp_t e;
        @(posedge clk);
        tick_id++;
        e = '{id: tick_id, instr: ins, pc4: pc4, pc: pc, valid: v, halt: h};
        last_e = e;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic tick_hold();
        tick(last_e.instr, last_e.pc4, last_e.pc, last_e.valid, last_e.halt);
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        bus.i_load_en   = 1'b1;
        bus.i_load_addr = a;
        bus.i_load_data = d;
        tick_hold();
        bus.i_load_en   = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.i_enable    = 1'b1;
        bus.i_stall     = 1'b0;
        bus.i_flush     = 1'b0;
        bus.i_target    = '0;
        bus.i_load_en   = 1'b0;
        bus.i_load_addr = '0;
        bus.i_load_data = '0;
        repeat (2) @(negedge clk);

        // Reset state
        tick(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Program load holds PC and IF/ID
        load(8'd0,   32'h20010005);
        load(8'd1,   32'h20020007);
        load(8'd2,   32'h20030009);
        load(8'd3,   32'h20040003);
        load(8'd16,  32'h24100010);
        load(8'd17,  32'h24110011);
        load(8'd255, 32'h240F00FF);

        // Sequential fetch
        tick(32'h20010005, 32'h4, 32'h4, 1'b1, 1'b0);
        tick(32'h20020007, 32'h8, 32'h8, 1'b1, 1'b0);

        // Two-cycle stall at PC=8
        bus.i_stall = 1'b1;
        tick_hold();
        tick_hold();
        bus.i_stall = 1'b0;
        tick(32'h20030009, 32'hC, 32'hC, 1'b1, 1'b0);

        // Enable low for three cycles, then a load pulse
        bus.i_enable = 1'b0;
        repeat (3) tick_hold();
        bus.i_enable = 1'b1;
        load(8'd5, 32'h20050005);
        tick(32'h20040003, 32'h10, 32'h10, 1'b1, 1'b0);

        // Flush at PC=0x10 to 0x40
        bus.i_flush  = 1'b1;
        bus.i_target = 32'h40;
        tick(32'h0, 32'h0, 32'h40, 1'b0, 1'b0);
        bus.i_flush  = 1'b0;
        tick(32'h24100010, 32'h44, 32'h44, 1'b1, 1'b0);
        tick(32'h24110011, 32'h48, 32'h48, 1'b1, 1'b0);

        // Flush together with stall: flush wins; then address wrap past word 255
        bus.i_flush  = 1'b1;
        bus.i_stall  = 1'b1;
        bus.i_target = 32'h3FC;
        tick(32'h0, 32'h0, 32'h3FC, 1'b0, 1'b0);
        bus.i_flush  = 1'b0;
        bus.i_stall  = 1'b0;
        tick(32'h240F00FF, 32'h400, 32'h400, 1'b1, 1'b0);
        tick(32'h20010005, 32'h404, 32'h404, 1'b1, 1'b0);

        // Reset mid-run with a load in flight: load is dropped
        rst_n           = 1'b0;
        bus.i_load_en   = 1'b1;
        bus.i_load_addr = 8'd0;
        bus.i_load_data = 32'hDEADBEEF;
        tick(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.i_load_en   = 1'b0;
        rst_n           = 1'b1;

        // HALT at word 3
        load(8'd3, 32'hFC000000);
        tick(32'h20010005, 32'h4, 32'h4, 1'b1, 1'b0);
        tick(32'h20020007, 32'h8, 32'h8, 1'b1, 1'b0);
        tick(32'h20030009, 32'hC, 32'hC, 1'b1, 1'b0);
        tick(32'hFC000000, 32'h10, 32'hC, 1'b1, 1'b1);
        tick(32'h0, 32'h10, 32'hC, 1'b0, 1'b1);
        bus.i_flush  = 1'b1;
        bus.i_stall  = 1'b1;
        bus.i_target = 32'h80;
        tick(32'h0, 32'h10, 32'hC, 1'b0, 1'b1);
        bus.i_flush  = 1'b0;
        bus.i_stall  = 1'b0;
        bus.i_enable = 1'b0;
        tick_hold();
        bus.i_enable = 1'b1;

        // Reset clears halt; flush on the HALT fetch cycle discards it
        rst_n = 1'b0;
        tick(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(32'h20010005, 32'h4, 32'h4, 1'b1, 1'b0);
        tick(32'h20020007, 32'h8, 32'h8, 1'b1, 1'b0);
        tick(32'h20030009, 32'hC, 32'hC, 1'b1, 1'b0);
        bus.i_flush  = 1'b1;
        bus.i_target = 32'h40;
        tick(32'h0, 32'h0, 32'h40, 1'b0, 1'b0);
        bus.i_flush  = 1'b0;
        tick(32'h24100010, 32'h44, 32'h44, 1'b1, 1'b0);

        // Scoreboard must drain within a bounded number of cycles
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the 5-stage MIPS pipeline, directly upstream of the instruction decoder.
- Holds the PC, a word-addressed instruction memory loadable by the debug unit, and the IF/ID pipeline register.
- Handles the decoder's stall and its branch/jump flush redirect.
- Detects HALT and freezes fetch.

Parameters:
- NB_PC, 32, PC and PC+4 width
- NB_INSTRUCTIONS, 32, instruction width
- NB_MEM_ADDR, 8, word-address bits of instruction memory (depth 2**NB_MEM_ADDR = 256 words)
- HALT_INSTR, 32'hFC000000, encoding of HALT (opcode 6'b111111, rest zero)

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  global step enable from debug unit; 0 freezes all stage state
- i_stall  in  1  load-use stall from hazard unit; holds PC and IF/ID
- i_flush  in  1  branch taken / jump resolved in ID; redirect PC, squash IF/ID
- i_target  in  NB_PC  redirect address, valid with i_flush
- i_load_en  in  1  instruction memory write strobe (debug loader)
- i_load_addr  in  NB_MEM_ADDR  word address for load
- i_load_data  in  NB_INSTRUCTIONS  word to write
- o_instruction  out  NB_INSTRUCTIONS  IF/ID instruction to decoder
- o_pc_plus4  out  NB_PC  IF/ID PC+4 (link value / branch base)
- o_pc  out  NB_PC  current PC register (debug readout)
- o_valid  out  1  IF/ID holds a real fetched instruction (0 = bubble)
- o_halt  out  1  sticky: HALT has been fetched and latched

Behaviour:
- Reset (i_reset=0, async):
  - PC=0, o_instruction=0 (NOP sll $0,$0,0), o_pc_plus4=0, o_valid=0, o_halt=0.
  - Instruction memory is not cleared; contents survive reset.
- Memory:
  - Write is synchronous: on rising edge with i_load_en=1, mem[i_load_addr] <= i_load_data, independent of i_enable.
  - Read is combinational at mem[PC[NB_MEM_ADDR+1:2]]; PC[1:0] are ignored.
  - Upper PC bits beyond NB_MEM_ADDR+2 are ignored, so fetch wraps modulo 1 KiB. The PC register itself does not wrap; it counts to 2**NB_PC.
- Per-edge update, evaluated in this priority order (first match wins):
  1. i_load_en=1: PC and IF/ID hold; the memory write occurs.
  2. i_enable=0: PC and IF/ID hold.
  3. o_halt=1: PC holds; IF/ID <= {0, PC+4, valid=0}, so the HALT word reaches ID exactly once followed by bubbles; i_stall and i_flush are ignored.
  4. i_flush=1: PC <= i_target; IF/ID <= {NOP, 0, valid=0}. A HALT fetched this cycle is on the wrong path and is discarded; o_halt is unchanged.
  5. i_stall=1: PC and IF/ID hold. A HALT at PC is not latched until the stall drops.
  6. Normal: IF/ID <= {mem[PC], PC+4, valid=1}. If mem[PC]==HALT_INSTR then o_halt<=1 and PC holds; otherwise PC <= PC+4.
- Latency: instruction at PC appears on o_instruction 1 cycle after the PC is presented; redirect costs 1 bubble.
- i_target low bits are taken as-is (no alignment check); misaligned targets fetch the containing word.
- o_pc reflects the PC register, not the IF/ID copy.
- Simultaneous i_flush and i_stall: flush wins. A stalled fetch is always wrong-path when ID resolves a redirect.
- Reset asserted mid-stall, mid-halt or mid-load: all state returns to reset values immediately; an in-flight load write on that edge is dropped.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- Load 0x20010005 at word 0 and 0x20020007 at word 1, release reset, i_enable=1 -> cycle1 o_instruction=0x20010005, o_pc_plus4=4, o_valid=1; cycle2 0x20020007, pc_plus4=8; o_pc=8.
- Assert i_stall for 2 cycles at PC=8 -> o_instruction, o_pc_plus4 and o_pc frozen for both cycles; fetch resumes at word 2 after release.
- i_flush=1 with i_target=0x40 at PC=0x10 -> next o_instruction=0, o_valid=0, o_pc=0x40; following cycle o_instruction=mem[16], o_pc_plus4=0x44.
- Place HALT at word 3 -> o_instruction=0xFC000000 once with o_halt=1 and o_pc=0x0C; afterwards o_valid=0 and o_pc stays 0x0C. Same setup with i_flush asserted on the HALT fetch cycle -> o_halt stays 0 and PC = i_target.
- i_enable=0 for 3 cycles mid-program, and separately i_load_en pulses -> no PC/IF/ID change. Reset pulse at PC=0x20 -> o_pc=0, o_valid=0, and the program refetches from word 0 with memory intact.
- Run PC to 0x3FC then 0x400 -> word 255 then word 0 fetched (address wrap); o_pc reads 0x400.
